// File: rtl/reflex_game_ctrl_if.sv
// Player-facing bus of the reflex game sequencer: switch/start inputs, the
// detector match line, and the LED drive plus score/timing display outputs.
`timescale 1ns/1ps
interface reflex_game_ctrl_if;
   logic        start;
   logic [15:0] sw;
   logic        hit;
   logic [15:0] led;
   logic [7:0]  score;
   logic [15:0] react_ms;
   logic [15:0] best_ms;
   logic        round_done;
   logic        last_hit;
   logic        busy;

   // Stimulus / board side: drives player inputs, observes the game outputs
   modport master (
      output start, sw, hit,
      input  led, score, react_ms, best_ms, round_done, last_hit, busy
   );

   // Sequencer side
   modport slave (
      input  start, sw, hit,
      output led, score, react_ms, best_ms, round_done, last_hit, busy
   );
endinterface

// File: rtl/reflex_game_ctrl.sv
// Reflex game sequencer: runs ROUNDS rounds of "wait for switches off,
// random pre-light delay, light one LED, time the player's matching switch".
// All outputs are registered; the LED bus updates on the edge entering a state.
`timescale 1ns/1ps
module reflex_game_ctrl #(
   parameter int unsigned TICK_DIV    = 100000,
   parameter int unsigned WAIT_MIN_MS = 500,
   parameter int unsigned TIMEOUT_MS  = 1000,
   parameter int unsigned ROUNDS      = 8,
   parameter int unsigned SHOW_MS     = 1000
) (
   input logic               clk,
   input logic               rst_n,
   reflex_game_ctrl_if.slave bus
);

   localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [15:0]       WAIT_MIN  = 16'(WAIT_MIN_MS);
   localparam logic [15:0]       TIMEOUT   = 16'(TIMEOUT_MS);
   localparam logic [15:0]       SHOW_LAST = 16'(SHOW_MS - 1);
   localparam logic [7:0]        ROUNDS_N  = 8'(ROUNDS);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ARM    = 3'd1;
   localparam logic [2:0] ST_DELAY  = 3'd2;
   localparam logic [2:0] ST_LIT    = 3'd3;
   localparam logic [2:0] ST_RESULT = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;

   // One-hot LED pattern for a 4-bit LED index
   function automatic logic [15:0] led_onehot(input logic [3:0] idx);
      return 16'h0001 << idx;
   endfunction

   logic [2:0]        state_r;
   logic [2:0]        state_nxt_s;
   logic [TICK_W-1:0] tick_cnt_r;
   logic [15:0]       ms_cnt_r;
   logic [15:0]       delay_ms_r;
   logic [3:0]        idx_r;
   logic [7:0]        round_cnt_r;
   logic [15:0]       lfsr_r;

   logic [15:0] led_r;
   logic [15:0] led_nxt_s;
   logic [7:0]  score_r;
   logic [15:0] react_ms_r;
   logic [15:0] best_ms_r;
   logic        round_done_r;
   logic        last_hit_r;
   logic        busy_r;

   logic tick_s;
   logic wrong_s;
   logic clear_s;
   logic lat_delay_s;
   logic lat_idx_s;
   logic hit_ev_s;
   logic miss_ev_s;
   logic round_end_s;

   assign bus.led        = led_r;
   assign bus.score      = score_r;
   assign bus.react_ms   = react_ms_r;
   assign bus.best_ms    = best_ms_r;
   assign bus.round_done = round_done_r;
   assign bus.last_hit   = last_hit_r;
   assign bus.busy       = busy_r;

   // Next-state decode and per-cycle round events
   always_comb begin
      tick_s      = (tick_cnt_r == TICK_LAST);
      wrong_s     = |(bus.sw & ~led_r);
      state_nxt_s = state_r;
      clear_s     = 1'b0;
      lat_delay_s = 1'b0;
      lat_idx_s   = 1'b0;
      hit_ev_s    = 1'b0;
      miss_ev_s   = 1'b0;
      round_end_s = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_nxt_s = ST_ARM;
               clear_s     = 1'b1;
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_ARM: begin
            if (bus.sw == 16'h0000) begin
               state_nxt_s = ST_DELAY;
               lat_delay_s = 1'b1;
            end else begin
               state_nxt_s = ST_ARM;
            end
         end
         ST_DELAY: begin
            // An early switch is a foul even on the cycle the delay would expire
            if (bus.sw != 16'h0000) begin
               state_nxt_s = ST_RESULT;
               miss_ev_s   = 1'b1;
            end else if (tick_s && (ms_cnt_r == delay_ms_r - 16'd1)) begin
               state_nxt_s = ST_LIT;
               lat_idx_s   = 1'b1;
            end else begin
               state_nxt_s = ST_DELAY;
            end
         end
         ST_LIT: begin
            // A clean hit wins over a simultaneous timeout; a wrong switch
            // spoils a simultaneous hit
            if (bus.hit && !wrong_s) begin
               state_nxt_s = ST_RESULT;
               hit_ev_s    = 1'b1;
            end else if (wrong_s || (ms_cnt_r == TIMEOUT)) begin
               state_nxt_s = ST_RESULT;
               miss_ev_s   = 1'b1;
            end else begin
               state_nxt_s = ST_LIT;
            end
         end
         ST_RESULT: begin
            if (tick_s && (ms_cnt_r == SHOW_LAST)) begin
               round_end_s = 1'b1;
               if (round_cnt_r + 8'd1 == ROUNDS_N) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_ARM;
               end
            end else begin
               state_nxt_s = ST_RESULT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // LED pattern to present from the edge that enters the next state
   always_comb begin
      led_nxt_s = 16'h0000;
      case (state_nxt_s)
         ST_LIT: begin
            if (lat_idx_s) begin
               led_nxt_s = led_onehot(lfsr_r[3:0]);
            end else begin
               led_nxt_s = led_r;
            end
         end
         ST_RESULT: begin
            if (hit_ev_s) begin
               led_nxt_s = 16'hFFFF;
            end else if (miss_ev_s) begin
               led_nxt_s = 16'h0000;
            end else begin
               led_nxt_s = led_r;
            end
         end
         ST_DONE: begin
            led_nxt_s = {score_r, score_r};
         end
         default: begin
            led_nxt_s = 16'h0000;
         end
      endcase
   end

   // Free-running LFSR; advancing in IDLE lets player timing seed the sequence
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_r <= 16'hACE1;
      end else begin
         lfsr_r <= {lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5], lfsr_r[15:1]};
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Millisecond tick and ms counter, both restarted on every state change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt_r <= '0;
         ms_cnt_r   <= 16'd0;
      end else if (state_nxt_s != state_r) begin
         tick_cnt_r <= '0;
         ms_cnt_r   <= 16'd0;
      end else if (tick_s) begin
         tick_cnt_r <= '0;
         ms_cnt_r   <= ms_cnt_r + 16'd1;
      end else begin
         tick_cnt_r <= tick_cnt_r + TICK_W'(1);
      end
   end

   // Round bookkeeping: delay/LED latches, score, timing results, flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         delay_ms_r   <= 16'd0;
         idx_r        <= 4'd0;
         round_cnt_r  <= 8'd0;
         led_r        <= 16'h0000;
         score_r      <= 8'd0;
         react_ms_r   <= 16'd0;
         best_ms_r    <= 16'hFFFF;
         round_done_r <= 1'b0;
         last_hit_r   <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         led_r        <= led_nxt_s;
         round_done_r <= hit_ev_s | miss_ev_s;
         busy_r       <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
         if (lat_delay_s) begin
            delay_ms_r <= WAIT_MIN + {8'd0, lfsr_r[7:0]};
         end
         if (lat_idx_s) begin
            idx_r <= lfsr_r[3:0];
         end
         if (clear_s) begin
            score_r     <= 8'd0;
            round_cnt_r <= 8'd0;
            react_ms_r  <= 16'd0;
         end else if (hit_ev_s) begin
            score_r    <= (score_r == 8'hFF) ? 8'hFF : score_r + 8'd1;
            react_ms_r <= ms_cnt_r;
            best_ms_r  <= (ms_cnt_r < best_ms_r) ? ms_cnt_r : best_ms_r;
         end else if (round_end_s) begin
            round_cnt_r <= round_cnt_r + 8'd1;
         end
         if (hit_ev_s) begin
            last_hit_r <= 1'b1;
         end else if (miss_ev_s) begin
            last_hit_r <= 1'b0;
         end
      end
   end

endmodule
